// File: rtl/axi_lite_pkt_tx_slave_if.sv
// Bus bundle for the packet-transmit slave: the ext_* AXI4-Lite-style
// CSR channel set and the outgoing tx_* word stream.
interface axi_lite_pkt_tx_slave_if;
    // Write address / data / response
    logic        ext_awvalid;
    logic        ext_awready;
    logic [31:0] ext_awaddr;
    logic        ext_wvalid;
    logic        ext_wready;
    logic [31:0] ext_wdata;
    logic [3:0]  ext_wstrb;
    logic        ext_bvalid;
    logic        ext_bready;
    // Read address / data
    logic        ext_arvalid;
    logic        ext_arready;
    logic [31:0] ext_araddr;
    logic        ext_rvalid;
    logic        ext_rready;
    logic [31:0] ext_rdata;
    // Outgoing word stream
    logic [31:0] tx_tdata;
    logic        tx_tlast;
    logic        tx_tvalid;
    logic        tx_tready;

    // Design side
    modport slave (
        input  ext_awvalid, ext_awaddr, ext_wvalid, ext_wdata, ext_wstrb,
        input  ext_bready, ext_arvalid, ext_araddr, ext_rready, tx_tready,
        output ext_awready, ext_wready, ext_bvalid, ext_arready, ext_rvalid,
        output ext_rdata, tx_tdata, tx_tlast, tx_tvalid
    );

    // CPU / accelerator side
    modport master (
        output ext_awvalid, ext_awaddr, ext_wvalid, ext_wdata, ext_wstrb,
        output ext_bready, ext_arvalid, ext_araddr, ext_rready, tx_tready,
        input  ext_awready, ext_wready, ext_bvalid, ext_arready, ext_rvalid,
        input  ext_rdata, tx_tdata, tx_tlast, tx_tvalid
    );
endinterface

// File: rtl/axi_lite_pkt_tx_slave.sv
// CSR slave with a first-word-fall-through transmit FIFO. The CPU pushes
// packet words over the ext_* bus; they drain as a valid/ready stream with
// a last marker. Register map on addr[3:2]: CTRL, STATUS, TXDATA, TXLAST.
module axi_lite_pkt_tx_slave #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    axi_lite_pkt_tx_slave_if.slave  bus
);
    localparam int PW = CW - 1;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_STATUS = 2'd1,
        REG_TXDATA = 2'd2,
        REG_TXLAST = 2'd3
    } reg_addr_e;

    // Write-channel holding state
    logic        aw_held_q, aw_held_d;
    logic        w_held_q,  w_held_d;
    reg_addr_e   awaddr_q,  awaddr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic        wstrb0_q,  wstrb0_d;
    logic        bvalid_q,  bvalid_d;
    // Read channel
    logic        rvalid_q,  rvalid_d;
    logic [31:0] rdata_q,   rdata_d;
    // CSRs
    logic        en_q,      en_d;
    logic        ovf_q,     ovf_d;
    // FIFO
    logic [32:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic        aw_hs, w_hs, ar_hs, wr_exec;
    reg_addr_e   wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic        wr_strb0;
    logic        full, empty, push_req, push, pop, flush, ovf_set, ovf_clr;
    logic        tvalid;
    logic [8:0]  cnt_ext;
    logic [31:0] status_word;

    assign bus.ext_awready = !aw_held_q && !bvalid_q;
    assign bus.ext_wready  = !w_held_q && !bvalid_q;
    assign bus.ext_bvalid  = bvalid_q;
    assign bus.ext_arready = !rvalid_q;
    assign bus.ext_rvalid  = rvalid_q;
    assign bus.ext_rdata   = rdata_q;

    assign aw_hs = bus.ext_awvalid && bus.ext_awready;
    assign w_hs  = bus.ext_wvalid  && bus.ext_wready;
    assign ar_hs = bus.ext_arvalid && bus.ext_arready;

    // A held half takes precedence over the bus; the write fires once both halves exist.
    assign wr_addr  = aw_held_q ? awaddr_q : reg_addr_e'(bus.ext_awaddr[3:2]);
    assign wr_data  = w_held_q  ? wdata_q  : bus.ext_wdata;
    assign wr_strb0 = w_held_q  ? wstrb0_q : bus.ext_wstrb[0];
    assign wr_exec  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign rd_addr  = reg_addr_e'(bus.ext_araddr[3:2]);

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign tvalid   = en_q && !empty;
    assign pop      = tvalid && bus.tx_tready;
    assign push_req = wr_exec && (wr_addr == REG_TXDATA || wr_addr == REG_TXLAST);
    assign push     = push_req && !full;
    assign ovf_set  = push_req && full;
    assign ovf_clr  = wr_exec && (wr_addr == REG_STATUS) && wr_data[2];
    assign flush    = wr_exec && (wr_addr == REG_CTRL) && wr_strb0 && wr_data[1];

    assign bus.tx_tvalid = tvalid;
    assign bus.tx_tdata  = mem[rd_ptr_q][31:0];
    assign bus.tx_tlast  = mem[rd_ptr_q][32];

    assign cnt_ext     = 9'(count_q);
    assign status_word = {16'h0, cnt_ext[7:0], 5'b0, ovf_q, full, empty};

    // Address bits and strobe lanes that never reach a register.
    logic unused_bits;
    assign unused_bits = ^{bus.ext_awaddr[31:4], bus.ext_awaddr[1:0],
                           bus.ext_araddr[31:4], bus.ext_araddr[1:0],
                           bus.ext_wstrb[3:1], cnt_ext[8]};

    // Write channel: latch AW/W independently, execute when both present, hold B until bready.
    always_comb begin
        // NOTE: every _d gets its current value first so no path leaves it unassigned (no latch).
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb0_d  = wstrb0_q;
        bvalid_d  = bvalid_q;
        if (bvalid_q && bus.ext_bready) begin
            bvalid_d = 1'b0;
        end
        if (wr_exec) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                awaddr_d  = reg_addr_e'(bus.ext_awaddr[3:2]);
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = bus.ext_wdata;
                wstrb0_d = bus.ext_wstrb[0];
            end
        end
    end

    // Read channel: capture pre-write register state on AR, hold until rready.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (rvalid_q && bus.ext_rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            unique case (rd_addr)
                REG_CTRL:   rdata_d = {31'b0, en_q};
                REG_STATUS: rdata_d = status_word;
                default:    rdata_d = '0;
            endcase
        end
    end

    // CSR and FIFO pointer/count next state; flush beats any same-cycle pop, OVF set beats clear.
    always_comb begin
        en_d     = en_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_exec && wr_addr == REG_CTRL && wr_strb0) begin
            en_d = wr_data[0];
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= REG_CTRL;
            wdata_q   <= '0;
            wstrb0_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            en_q      <= 1'b0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb0_q  <= wstrb0_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            en_q      <= en_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage: word plus last flag at the write pointer.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count/pointers alone decide which entries are valid.
        if (push) begin
            mem[wr_ptr_q] <= {wr_addr == REG_TXLAST, wr_data};
        end
    end

endmodule

// File: tb/tb_axi_lite_pkt_tx_slave.sv
// Directed bench for axi_lite_pkt_tx_slave. Expected stream words go into a
// scoreboard queue as they are pushed over the bus and are compared against
// words captured by a monitor on each stream handshake.
`timescale 1ns/1ps
module tb_axi_lite_pkt_tx_slave;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_pkt_tx_slave_if bus ();

    axi_lite_pkt_tx_slave #(.DEPTH(DEPTH), .CW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [32:0] exp_q [$];
    logic [32:0] obs_mem [256];
    int          obs_wr = 0;
    int          obs_rd = 0;

    // Stream monitor: record every word that handshakes at the coming edge.
    always @(negedge clk) begin
        if (!rst && bus.tx_tvalid && bus.tx_tready && obs_wr < 256) begin
            obs_mem[obs_wr] <= {bus.tx_tlast, bus.tx_tdata};
            obs_wr          <= obs_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input string tag);
        logic aw_go, w_go;
        int k;
        bus.ext_awaddr  = addr;
        bus.ext_wdata   = data;
        bus.ext_wstrb   = strb;
        bus.ext_awvalid = 1'b1;
        bus.ext_wvalid  = 1'b1;
        bus.ext_bready  = 1'b1;
        k = 0;
        while ((bus.ext_awvalid || bus.ext_wvalid) && k < 20) begin
            aw_go = bus.ext_awvalid && bus.ext_awready;
            w_go  = bus.ext_wvalid && bus.ext_wready;
            tick();
            if (aw_go) bus.ext_awvalid = 1'b0;
            if (w_go)  bus.ext_wvalid  = 1'b0;
            k++;
        end
        bus.ext_awvalid = 1'b0;
        bus.ext_wvalid  = 1'b0;
        k = 0;
        while (!bus.ext_bvalid && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_bvalid"}, {32'b0, bus.ext_bvalid}, 33'd1);
        tick();
        bus.ext_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        logic go;
        int k;
        bus.ext_araddr  = addr;
        bus.ext_arvalid = 1'b1;
        bus.ext_rready  = 1'b0;
        k = 0;
        while (bus.ext_arvalid && k < 20) begin
            go = bus.ext_arready;
            tick();
            if (go) bus.ext_arvalid = 1'b0;
            k++;
        end
        bus.ext_arvalid = 1'b0;
        k = 0;
        while (!bus.ext_rvalid && k < 20) begin
            tick();
            k++;
        end
        data = bus.ext_rvalid ? bus.ext_rdata : 32'hxxxx_xxxx;
        bus.ext_rready = 1'b1;
        tick();
        bus.ext_rready = 1'b0;
    endtask

    task automatic read_chk(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        axi_read(addr, d);
        chk(tag, {1'b0, d}, {1'b0, exp});
    endtask

    task automatic push_word(input logic last, input logic [31:0] data, input string tag);
        axi_write(last ? 32'hC : 32'h8, data, 4'hF, tag);
        exp_q.push_back({last, data});
    endtask

    task automatic expect_stream(input int n, input string tag);
        int k;
        logic [32:0] got;
        logic [32:0] exp;
        k = 0;
        while ((obs_wr - obs_rd) < n && k < 500) begin
            tick();
            k++;
        end
        for (int i = 0; i < n; i++) begin
            got = (obs_rd < obs_wr) ? obs_mem[obs_rd] : 33'hx_xxxx_xxxx;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
            chk($sformatf("%s_%0d", tag, i), got, exp);
            obs_rd++;
        end
    endtask

    // Split write with bready held low two cycles; exactly one push expected.
    task automatic split_write(input logic aw_first, input logic [31:0] addr,
                               input logic [31:0] data, input string tag);
        bus.ext_bready = 1'b0;
        bus.ext_awaddr = addr;
        bus.ext_wdata  = data;
        bus.ext_wstrb  = 4'hF;
        if (aw_first) begin
            chk({tag, "_awready0"}, {32'b0, bus.ext_awready}, 33'd1);
            bus.ext_awvalid = 1'b1;
            tick();
            bus.ext_awvalid = 1'b0;
            chk({tag, "_awready_held"}, {32'b0, bus.ext_awready}, 33'd0);
            tick();
            tick();
            chk({tag, "_wready0"}, {32'b0, bus.ext_wready}, 33'd1);
            bus.ext_wvalid = 1'b1;
            tick();
            bus.ext_wvalid = 1'b0;
        end else begin
            chk({tag, "_wready0"}, {32'b0, bus.ext_wready}, 33'd1);
            bus.ext_wvalid = 1'b1;
            tick();
            bus.ext_wvalid = 1'b0;
            chk({tag, "_wready_held"}, {32'b0, bus.ext_wready}, 33'd0);
            tick();
            tick();
            chk({tag, "_awready0"}, {32'b0, bus.ext_awready}, 33'd1);
            bus.ext_awvalid = 1'b1;
            tick();
            bus.ext_awvalid = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("%s_bvalid_hold%0d", tag, c), {32'b0, bus.ext_bvalid}, 33'd1);
            chk($sformatf("%s_rdy_low%0d", tag, c),
                {31'b0, bus.ext_awready, bus.ext_wready}, 33'd0);
            tick();
        end
        bus.ext_bready = 1'b1;
        tick();
        bus.ext_bready = 1'b0;
        chk({tag, "_bvalid_clr"}, {32'b0, bus.ext_bvalid}, 33'd0);
        chk({tag, "_awready_back"}, {32'b0, bus.ext_awready}, 33'd1);
        exp_q.push_back({addr[2], data});
    endtask

    initial begin
        bus.ext_awvalid = 1'b0;
        bus.ext_awaddr  = '0;
        bus.ext_wvalid  = 1'b0;
        bus.ext_wdata   = '0;
        bus.ext_wstrb   = '0;
        bus.ext_bready  = 1'b0;
        bus.ext_arvalid = 1'b0;
        bus.ext_araddr  = '0;
        bus.ext_rready  = 1'b0;
        bus.tx_tready   = 1'b0;

        // 1. Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bvalid", {32'b0, bus.ext_bvalid}, 33'd0);
        chk("rst_rvalid", {32'b0, bus.ext_rvalid}, 33'd0);
        chk("rst_rdata",  {1'b0, bus.ext_rdata},   33'd0);
        chk("rst_tvalid", {32'b0, bus.tx_tvalid},  33'd0);
        rst = 1'b0;
        #1;
        chk("rst_readies", {30'b0, bus.ext_awready, bus.ext_wready, bus.ext_arready}, 33'h7);
        tick();
        read_chk(32'h4, 32'h0000_0001, "rst_status");
        read_chk(32'h0, 32'h0000_0000, "rst_ctrl");

        // 2. Enabled stream of a three-word packet
        bus.tx_tready = 1'b1;
        axi_write(32'h0, 32'h1, 4'hF, "ctrl_en");
        push_word(1'b0, 32'hA0, "push_a0");
        push_word(1'b0, 32'hA1, "push_a1");
        push_word(1'b1, 32'hA2, "push_a2");
        expect_stream(3, "pkt_a");
        read_chk(32'h4, 32'h0000_0001, "pkt_a_status");

        // 3. Fill with stream disabled, overflow, W1C, then drain
        axi_write(32'h0, 32'h0, 4'hF, "ctrl_dis");
        for (int i = 0; i < DEPTH; i++) begin
            push_word(i == DEPTH - 1, 32'h100 + 32'(i), $sformatf("fill%0d", i));
        end
        axi_write(32'h8, 32'hDEAD_BEEF, 4'hF, "ovf_push");
        read_chk(32'h4, 32'h0000_1006, "full_ovf_status");
        axi_write(32'h4, 32'h4, 4'hF, "ovf_w1c");
        read_chk(32'h4, 32'h0000_1002, "w1c_status");
        axi_write(32'h0, 32'h1, 4'hF, "ctrl_drain");
        expect_stream(DEPTH, "drain");
        read_chk(32'h4, 32'h0000_0001, "drain_status");

        // 4. AW/W skew with bready stalled
        axi_write(32'h0, 32'h0, 4'hF, "ctrl_dis2");
        split_write(1'b1, 32'h8, 32'hB0, "aw_first");
        read_chk(32'h4, 32'h0000_0100, "aw_first_status");
        split_write(1'b0, 32'hC, 32'hB1, "w_first");
        read_chk(32'h4, 32'h0000_0200, "w_first_status");

        // 5. Flush with five words queued
        push_word(1'b0, 32'hC0, "push_c0");
        push_word(1'b0, 32'hC1, "push_c1");
        push_word(1'b1, 32'hC2, "push_c2");
        read_chk(32'h4, 32'h0000_0500, "pre_flush_status");
        axi_write(32'h0, 32'h3, 4'hF, "ctrl_flush");
        exp_q.delete();
        chk("flush_tvalid", {32'b0, bus.tx_tvalid}, 33'd0);
        chk("flush_no_pop", 33'(obs_wr - obs_rd), 33'd0);
        read_chk(32'h4, 32'h0000_0001, "flush_status");
        read_chk(32'h0, 32'h0000_0001, "flush_ctrl_reads_en");
        read_chk(32'h8, 32'h0000_0000, "txdata_reads0");
        read_chk(32'hC, 32'h0000_0000, "txlast_reads0");
        push_word(1'b1, 32'hD0, "push_d0");
        expect_stream(1, "post_flush");

        // 6. Asynchronous reset with a pending read and queued words
        bus.tx_tready = 1'b0;
        push_word(1'b0, 32'hE0, "push_e0");
        push_word(1'b0, 32'hE1, "push_e1");
        push_word(1'b1, 32'hE2, "push_e2");
        chk("pre_rst_tvalid", {32'b0, bus.tx_tvalid}, 33'd1);
        bus.ext_araddr  = 32'h4;
        bus.ext_arvalid = 1'b1;
        tick();
        bus.ext_arvalid = 1'b0;
        chk("pre_rst_rvalid", {32'b0, bus.ext_rvalid}, 33'd1);
        chk("pre_rst_rdata", {1'b0, bus.ext_rdata}, 33'h0000_0300);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rvalid", {32'b0, bus.ext_rvalid}, 33'd0);
        chk("async_tvalid", {32'b0, bus.tx_tvalid}, 33'd0);
        chk("async_rdata",  {1'b0, bus.ext_rdata},  33'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_readies", {30'b0, bus.ext_awready, bus.ext_wready, bus.ext_arready}, 33'h7);
        read_chk(32'h4, 32'h0000_0001, "post_rst_status");
        read_chk(32'h0, 32'h0000_0000, "post_rst_ctrl");
        chk("no_extra_words", 33'(obs_wr - obs_rd), 33'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
